// File: rtl/score_bcd_sequencer_pkg.sv
// Shared constants, FSM encoding and helpers for the score BCD sequencer.
// Everything that sizes the converter lives here so the top and the
// dabble step always agree on register layout.
package score_pkg;

   // Binary score width, BCD digits per result and the clamp ceiling.
   localparam int SCORE_W = 20;
   localparam int NDIG    = 7;
   localparam int BCD_W   = 4 * NDIG;
   localparam int SR_W    = BCD_W + SCORE_W;
   localparam int CNT_W   = 5;

   localparam logic [SCORE_W-1:0] MAX_SCORE = 20'd1000000;

   // Digit positions inside a packed BCD result (nibble index).
   localparam int DIG_ONES      = 0;
   localparam int DIG_TENS      = 1;
   localparam int DIG_HUNDREDS  = 2;
   localparam int DIG_THOUSANDS = 3;
   localparam int DIG_TENK      = 4;
   localparam int DIG_HUNDREDK  = 5;
   localparam int DIG_MILLIONS  = 6;

   // Converter sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Saturate a raw score at the display ceiling (unsigned compare).
   function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
      return (s > MAX_SCORE) ? MAX_SCORE : s;
   endfunction

   // Flag for scores that would not fit on the display.
   function automatic logic score_saturates(input logic [SCORE_W-1:0] s);
      return (s > MAX_SCORE);
   endfunction

endpackage

// File: rtl/score_bcd_sequencer_dabble.sv
// One iteration of the shift-add-3 (double dabble) algorithm.
// The register is {BCD digits, binary remainder}; every BCD nibble that is
// 5 or more is corrected by +3, then the whole register shifts left by one.
module bcd_dabble_step
   import score_pkg::*;
(
   input  logic [SR_W-1:0] sr_in,
   output logic [SR_W-1:0] sr_out
);

   logic [SR_W-1:0] adj;

   // Correct each BCD nibble before the shift so no digit overflows past 9.
   always_comb begin
      adj = sr_in;
      for (int k = 0; k < NDIG; k++) begin
         if (sr_in[SCORE_W + 4*k +: 4] >= 4'd5) begin
            adj[SCORE_W + 4*k +: 4] = sr_in[SCORE_W + 4*k +: 4] + 4'd3;
         end
      end
      sr_out = adj << 1;
   end

endmodule

// File: rtl/score_bcd_sequencer.sv
// Two-channel binary-to-BCD score converter sharing one serial engine.
// ch0 (live score) and ch1 (best score) are arbitrated round-robin; each
// channel keeps its own registered 7-digit result, saturation flag and
// valid flag, and gets a one-cycle ack when its result is refreshed.
module score_bcd_sequencer
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               req0,
   input  logic [SCORE_W-1:0] score0,
   input  logic               req1,
   input  logic [SCORE_W-1:0] score1,
   output logic               ack0,
   output logic               ack1,
   output logic [BCD_W-1:0]   digits0,
   output logic [BCD_W-1:0]   digits1,
   output logic               valid0,
   output logic               valid1,
   output logic               sat0,
   output logic               sat1,
   output logic               busy
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SCORE_W - 1);

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   cnt;
   logic [SR_W-1:0]    sr;
   logic [SR_W-1:0]    sr_step;
   logic               grant;
   logic               last_grant;
   logic               snap_sat;
   logic               pick;
   logic               start;
   logic [SCORE_W-1:0] pick_score;
   logic [BCD_W-1:0]   bcd_result;

   bcd_dabble_step u_step (
      .sr_in  (sr),
      .sr_out (sr_step)
   );

   assign bcd_result = sr[SR_W-1:SCORE_W];

   // Round-robin pick: a lone request wins; on a tie the channel that was not served last wins.
   always_comb begin
      pick = 1'b0;
      if (req0 && req1) begin
         pick = ~last_grant;
      end else if (req1) begin
         pick = 1'b1;
      end
      start      = (state == ST_IDLE) && (req0 || req1);
      pick_score = pick ? score1 : score0;
   end

   // Next-state logic: one load cycle, SCORE_W shift iterations, one write-back cycle.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt == LAST_ITER) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State register, with busy registered alongside so it tracks SHIFT/DONE exactly.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != ST_IDLE);
      end
   end

   // Engine datapath: snapshot and clamp at grant, then iterate the dabble step.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr       <= '0;
         cnt      <= '0;
         grant    <= 1'b0;
         snap_sat <= 1'b0;
      end else begin
         if (start) begin
            grant    <= pick;
            snap_sat <= score_saturates(pick_score);
            sr       <= {{BCD_W{1'b0}}, clamp_score(pick_score)};
            cnt      <= '0;
         end else if (state == ST_SHIFT) begin
            sr  <= sr_step;
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Result write-back: only the granted channel's outputs change, and ack pulses for one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         digits0    <= '0;
         digits1    <= '0;
         valid0     <= 1'b0;
         valid1     <= 1'b0;
         sat0       <= 1'b0;
         sat1       <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         if (state == ST_DONE) begin
            last_grant <= grant;
            if (grant) begin
               digits1 <= bcd_result;
               sat1    <= snap_sat;
               valid1  <= 1'b1;
               ack1    <= 1'b1;
            end else begin
               digits0 <= bcd_result;
               sat0    <= snap_sat;
               valid0  <= 1'b1;
               ack0    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_bcd_sequencer.sv
// Directed testbench for score_bcd_sequencer: reset values, conversion
// results, clamp behaviour, arbitration order, score snapshotting and
// mid-conversion reset.
module tb_score_bcd_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [19:0] score0 = '0;
   logic [19:0] score1 = '0;
   logic        ack0, ack1, valid0, valid1, sat0, sat1, busy;
   logic [27:0] digits0, digits1;

   int tests_run = 0;
   int tests_failed = 0;
   int spurious = 0;

   score_bcd_sequencer dut (
      .clk     (clk),
      .resetn  (resetn),
      .req0    (req0),
      .score0  (score0),
      .req1    (req1),
      .score1  (score1),
      .ack0    (ack0),
      .ack1    (ack1),
      .digits0 (digits0),
      .digits1 (digits1),
      .valid0  (valid0),
      .valid1  (valid1),
      .sat0    (sat0),
      .sat1    (sat1),
      .busy    (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Request one conversion on a channel and wait (bounded) for its ack.
   // lat = number of edges from the sampling edge E0 (counted as 1) to ack.
   task automatic applyStimulus(input int ch, input logic [19:0] sc, input int alt_edge,
                                input logic [19:0] alt_sc, output int lat);
      lat = -1;
      if (ch == 0) begin score0 = sc; req0 = 1'b1; end
      else         begin score1 = sc; req1 = 1'b1; end
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (alt_edge > 0 && k == alt_edge + 1) begin
            if (ch == 0) score0 = alt_sc; else score1 = alt_sc;
         end
         if ((ch == 0 && ack1) || (ch == 1 && ack0)) spurious++;
         if ((ch == 0 && ack0) || (ch == 1 && ack1)) begin
            lat = k;
            break;
         end
      end
      if (ch == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      int lat;
      int a0_1, a0_2, a1_1;
      logic [27:0] d0, d1;

      #3 resetn = 1'b0;
      #1;
      checkOutput("rst digits0", digits0, 28'h0);
      checkOutput("rst digits1", digits1, 28'h0);
      checkOutput("rst flags", {valid0, valid1, sat0, sat1, ack0, ack1, busy}, 7'b0);
      @(posedge clk); @(posedge clk);
      #2 resetn = 1'b1;
      @(posedge clk); #1;

      // 1: zero score
      applyStimulus(0, 20'd0, 0, 20'd0, lat);
      checkOutput("t1 latency", lat, 22);
      checkOutput("t1 digits0", digits0, 28'h0000000);
      checkOutput("t1 valid0", valid0, 1);
      checkOutput("t1 sat0", sat0, 0);
      checkOutput("t1 valid1", valid1, 0);
      @(posedge clk); #1;
      checkOutput("t1 ack0 pulse width", ack0, 0);

      // 2: large in-range value, then exactly the ceiling
      applyStimulus(0, 20'd987654, 0, 20'd0, lat);
      checkOutput("t2a latency", lat, 22);
      checkOutput("t2a digits0", digits0, 28'h0987654);
      applyStimulus(0, 20'd1000000, 0, 20'd0, lat);
      checkOutput("t2b latency", lat, 22);
      checkOutput("t2b digits0", digits0, 28'h1000000);
      checkOutput("t2b sat0", sat0, 0);
      @(posedge clk); #1;

      // 3: max binary value clamps on ch1
      applyStimulus(1, 20'd1048575, 0, 20'd0, lat);
      checkOutput("t3 latency", lat, 22);
      checkOutput("t3 digits1", digits1, 28'h1000000);
      checkOutput("t3 sat1", sat1, 1);
      checkOutput("t3 valid1", valid1, 1);
      checkOutput("t3 digits0 held", digits0, 28'h1000000);
      @(posedge clk); #1;
      checkOutput("t3 ack1 pulse width", ack1, 0);

      // 4: simultaneous requests held, channels alternate
      a0_1 = -1; a0_2 = -1; a1_1 = -1; d0 = '0; d1 = '0;
      score0 = 20'd123; score1 = 20'd456;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 1; k <= 66; k++) begin
         @(posedge clk); #1;
         if (ack0 && ack1) spurious++;
         if (ack0) begin
            if (a0_1 < 0) begin a0_1 = k; d0 = digits0; end
            else if (a0_2 < 0) a0_2 = k;
         end
         if (ack1 && a1_1 < 0) begin a1_1 = k; d1 = digits1; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checkOutput("t4 first ack0 edge", a0_1, 22);
      checkOutput("t4 first ack0 digits0", d0, 28'h0000123);
      checkOutput("t4 ack1 edge", a1_1, 44);
      checkOutput("t4 ack1 digits1", d1, 28'h0000456);
      checkOutput("t4 second ack0 edge", a0_2, 66);
      @(posedge clk); @(posedge clk); #1;
      checkOutput("t4 idle after drop", busy, 0);

      // 5: score change after grant is ignored
      applyStimulus(0, 20'd500, 5, 20'd777, lat);
      checkOutput("t5 latency", lat, 22);
      checkOutput("t5 score0 changed", score0, 20'd777);
      checkOutput("t5 digits0", digits0, 28'h0000500);
      @(posedge clk); #1;

      // 6: reset mid-conversion
      score0 = 20'd999; req0 = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      checkOutput("t6 busy before reset", busy, 1);
      resetn = 1'b0;
      #1;
      req0 = 1'b0;
      checkOutput("t6 rst digits0", digits0, 28'h0);
      checkOutput("t6 rst digits1", digits1, 28'h0);
      checkOutput("t6 rst flags", {valid0, valid1, sat0, sat1, ack0, ack1, busy}, 7'b0);
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (ack0 || ack1) spurious++;
      end
      checkOutput("t6 idle after release", busy, 0);
      applyStimulus(0, 20'd42, 0, 20'd0, lat);
      checkOutput("t6 latency", lat, 22);
      checkOutput("t6 digits0", digits0, 28'h0000042);
      checkOutput("t6 valid1 cleared", valid1, 0);

      checkOutput("no spurious acks", spurious, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
